stump_control_fsm: RTL and testbench
====================================

// Module: stump_control_fsm
// PURPOSE
//  Fetch/execute/memory sequencer for the Stump datapath. Decodes the Q output of the
//  16-bit instruction register and generates that register's CE (ir_en) plus the
//  register-bank, CC and memory enables. It sits directly upstream of every datapath register.
//  Memory accesses wait on a ready handshake; branches are resolved against the NZVC flags.
// PARAMETERS
//  PC_REG   3'd7   register-bank index of the program counter
// PORTS
//  CLK           in   1   system clock, all state changes on rising edge
//  RST           in   1   synchronous reset, active-high
//  ir            in   16  current instruction (Q of instruction register)
//  cc            in   4   flags {N,Z,V,C} from status register
//  mem_rdy       in   1   memory completes current read/write this cycle
//  fetch         out  1   state == FETCH
//  execute       out  1   state == EXECUTE
//  memory        out  1   state == MEMORY
//  ir_en         out  1   CE for instruction register
//  reg_write     out  1   register-bank write enable
//  reg_dest      out  3   register-bank write index
//  cc_en         out  1   CE for status register
//  mem_ren       out  1   memory read strobe
//  mem_wen       out  1   memory write strobe
//  addr_sel      out  1   0: address = PC, 1: address = ALU result
//  branch_taken  out  1   EXECUTE of Bcc with condition true
// BEHAVIOUR
//  - Decode: op=ir[15:13], type=ir[12], S/cond=ir[11:8], dest=ir[10:8]. ALU ops 000-101,
//    110 LD/ST (ir[11]=1 store), 111 Bcc (cond=ir[11:8], any type).
//  - State: 2-bit register, FETCH/EXECUTE/MEMORY, one-hot decode on fetch/execute/memory;
//    encoding 2'b11 is illegal -> next state FETCH, all enables 0.
//  - Reset: RST high at an edge -> state=FETCH. While RST high, every enable/strobe output
//    (ir_en, reg_write, cc_en, mem_ren, mem_wen, branch_taken) is forced 0; reg_dest=0,
//    addr_sel=0. RST mid-MEMORY drops the access; no write is issued.
//  - All outputs combinational from state, ir, cc, mem_rdy. Next state registered.
//  - FETCH: mem_ren=1, addr_sel=0. If mem_rdy: ir_en=1, reg_write=1, reg_dest=PC_REG
//    (PC+1), next EXECUTE. Else: ir_en=0, reg_write=0, stay in FETCH (unbounded wait).
//  - EXECUTE, ALU op: reg_write=1, reg_dest=dest, cc_en=ir[11]; next FETCH. dest=PC_REG
//    is legal (computed jump).
//  - EXECUTE, LD/ST: reg_write=0, cc_en=0, no strobes; next MEMORY.
//  - EXECUTE, Bcc: branch_taken=cond_true; reg_write=cond_true, reg_dest=PC_REG; cc_en=0;
//    next FETCH.
//  - Cond (ir[11:8]): 0 AL,1 NV,2 HI !C&!Z,3 LS C|Z,4 CC !C,5 CS C,6 NE !Z,7 EQ Z,
//    8 VC !V,9 VS V,A PL !N,B MI N,C GE N==V,D LT N!=V,E GT !Z&(N==V),F LE Z|(N!=V).
//  - MEMORY: addr_sel=1. Load: mem_ren=1; if mem_rdy, reg_write=1, reg_dest=dest.
//    Store: mem_wen=1, reg_write=0. mem_rdy=1 -> next FETCH; else stay, strobes held.
//  - cc_en is 0 outside EXECUTE. mem_ren and mem_wen are never both 1.
//  - ir_en is 1 only in FETCH with mem_rdy, so ir is stable through EXECUTE and MEMORY.
//  - reg_dest is 0 whenever reg_write=0.
// TESTING
//  1 RST=1 two cycles then 0, mem_rdy=1 -> fetch=1, ir_en=1, reg_write=1, reg_dest=7 on
//    first post-reset cycle; all strobes 0 while RST=1.
//  2 FETCH mem_rdy=0 x3 then 1 -> fetch held 4 cycles, ir_en only on 4th; ir=16'h0A2C ->
//    EXECUTE: reg_write=1, reg_dest=2, cc_en=1; then FETCH.
//  3 ir=16'hD385 (LD r3), mem_rdy=0 x2 in MEMORY -> mem_ren=1, addr_sel=1 throughout;
//    reg_write=1 reg_dest=3 only on the mem_rdy cycle.
//  4 ir=16'hDB85 (ST) -> MEMORY mem_wen=1, mem_ren=0, reg_write=0; cc_en=0 in EXECUTE.
//  5 ir=16'hF705 (BEQ): cc=4'b0100 -> branch_taken=1, reg_write=1, reg_dest=7;
//    cc=4'b0000 -> both 0. Sweep all 16 conds x 16 cc values against the table.
//  6 RST=1 in MEMORY of a store with mem_rdy=0 -> mem_wen=0 that cycle; next state FETCH.

Source files
------------

// File: rtl/stump_control_fsm.sv
// Stump fetch/execute/memory sequencer.
// Decodes ir and drives the datapath register and memory enables.
module stump_control_fsm #(
  parameter logic [2:0] PC_REG = 3'd7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ir,
  input  logic [3:0]  cc,
  input  logic        mem_rdy,
  output logic        fetch,
  output logic        execute,
  output logic        memory,
  output logic        ir_en,
  output logic        reg_write,
  output logic [2:0]  reg_dest,
  output logic        cc_en,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic        addr_sel,
  output logic        branch_taken
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_MEM   = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0] w_op;
  logic       w_is_alu;
  logic       w_is_ldst;
  logic       w_is_bcc;
  logic       w_store;
  logic       w_s_bit;
  logic [2:0] w_dest;
  logic [3:0] w_cond;
  logic       w_cond_true;
  logic       w_n;
  logic       w_z;
  logic       w_v;
  logic       w_c;

  assign w_op      = ir[15:13];
  assign w_s_bit   = ir[11];
  assign w_store   = ir[11];
  assign w_dest    = ir[10:8];
  assign w_cond    = ir[11:8];
  assign w_is_alu  = (w_op <= 3'd5);
  assign w_is_ldst = (w_op == 3'd6);
  assign w_is_bcc  = (w_op == 3'd7);

  assign w_n = cc[3];
  assign w_z = cc[2];
  assign w_v = cc[1];
  assign w_c = cc[0];

  // branch condition evaluated against the NZVC flags
  always_comb begin
    w_cond_true = 1'b0;
    unique case (w_cond)
      4'h0: w_cond_true = 1'b1;
      4'h1: w_cond_true = 1'b0;
      4'h2: w_cond_true = ~w_c & ~w_z;
      4'h3: w_cond_true = w_c | w_z;
      4'h4: w_cond_true = ~w_c;
      4'h5: w_cond_true = w_c;
      4'h6: w_cond_true = ~w_z;
      4'h7: w_cond_true = w_z;
      4'h8: w_cond_true = ~w_v;
      4'h9: w_cond_true = w_v;
      4'hA: w_cond_true = ~w_n;
      4'hB: w_cond_true = w_n;
      4'hC: w_cond_true = (w_n == w_v);
      4'hD: w_cond_true = (w_n != w_v);
      4'hE: w_cond_true = ~w_z & (w_n == w_v);
      4'hF: w_cond_true = w_z | (w_n != w_v);
      default: w_cond_true = 1'b0;
    endcase
  end

  // state register, synchronous reset to FETCH
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  assign fetch   = (r_state == S_FETCH);
  assign execute = (r_state == S_EXEC);
  assign memory  = (r_state == S_MEM);

  // next state and datapath enables; reset masks every enable
  always_comb begin
    w_next       = S_FETCH;
    ir_en        = 1'b0;
    reg_write    = 1'b0;
    reg_dest     = 3'd0;
    cc_en        = 1'b0;
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    addr_sel     = 1'b0;
    branch_taken = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_ren = 1'b1;
        if (mem_rdy) begin
          ir_en     = 1'b1;
          reg_write = 1'b1;
          reg_dest  = PC_REG;
          w_next    = S_EXEC;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          w_is_alu: begin
            reg_write = 1'b1;
            reg_dest  = w_dest;
            cc_en     = w_s_bit;
            w_next    = S_FETCH;
          end
          w_is_ldst: begin
            w_next = S_MEM;
          end
          w_is_bcc: begin
            branch_taken = w_cond_true;
            reg_write    = w_cond_true;
            reg_dest     = w_cond_true ? PC_REG : 3'd0;
            w_next       = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        addr_sel = 1'b1;
        if (w_store) begin
          mem_wen = 1'b1;
        end else begin
          mem_ren = 1'b1;
          if (mem_rdy) begin
            reg_write = 1'b1;
            reg_dest  = w_dest;
          end
        end
        w_next = mem_rdy ? S_FETCH : S_MEM;
      end
      default: w_next = S_FETCH;
    endcase
    if (RST) begin
      w_next       = S_FETCH;
      ir_en        = 1'b0;
      reg_write    = 1'b0;
      reg_dest     = 3'd0;
      cc_en        = 1'b0;
      mem_ren      = 1'b0;
      mem_wen      = 1'b0;
      addr_sel     = 1'b0;
      branch_taken = 1'b0;
    end
  end

endmodule

// File: tb/tb_stump_control_fsm.sv
// Scoreboard bench for stump_control_fsm.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_stump_control_fsm;

  logic        CLK;
  logic        RST;
  logic [15:0] ir;
  logic [3:0]  cc;
  logic        mem_rdy;
  logic        fetch;
  logic        execute;
  logic        memory;
  logic        ir_en;
  logic        reg_write;
  logic [2:0]  reg_dest;
  logic        cc_en;
  logic        mem_ren;
  logic        mem_wen;
  logic        addr_sel;
  logic        branch_taken;

  stump_control_fsm dut (
    .CLK(CLK),
    .RST(RST),
    .ir(ir),
    .cc(cc),
    .mem_rdy(mem_rdy),
    .fetch(fetch),
    .execute(execute),
    .memory(memory),
    .ir_en(ir_en),
    .reg_write(reg_write),
    .reg_dest(reg_dest),
    .cc_en(cc_en),
    .mem_ren(mem_ren),
    .mem_wen(mem_wen),
    .addr_sel(addr_sel),
    .branch_taken(branch_taken)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [12:0] v;
    int          id;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int ncyc = 0;

  // model phase: 0 fetch, 1 execute, 2 memory
  int ph = 0;

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v, cy, base;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c >> 1)
      0: base = 1;
      1: base = !cy && !z;
      2: base = !cy;
      3: base = !z;
      4: base = !v;
      5: base = !n;
      6: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  // one clock of stimulus: drive inputs, predict outputs, advance model
  task automatic cyc(input bit rst, input logic [15:0] i,
                     input logic [3:0] f, input bit rdy);
    bit fe, ex, me, ie, rw, ce, rr, ww, as, bt;
    int dst, nph, op;
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst; ir = i; cc = f; mem_rdy = rdy;
    fe = (ph == 0); ex = (ph == 1); me = (ph == 2);
    ie = 0; rw = 0; ce = 0; rr = 0; ww = 0; as = 0; bt = 0;
    dst = 0; nph = 0;
    op = int'(i[15:13]);
    if (ph == 0) begin
      rr = 1;
      if (rdy) begin ie = 1; rw = 1; dst = 7; nph = 1; end
      else nph = 0;
    end else if (ph == 1) begin
      if (op < 6) begin
        rw = 1; dst = int'(i[10:8]); ce = i[11];
      end else if (op == 6) begin
        nph = 2;
      end else begin
        bt = cond_ok(i[11:8], f);
        rw = bt; dst = bt ? 7 : 0;
      end
    end else begin
      as = 1;
      if (i[11]) ww = 1;
      else begin
        rr = 1;
        if (rdy) begin rw = 1; dst = int'(i[10:8]); end
      end
      nph = rdy ? 0 : 2;
    end
    if (rst) begin
      ie = 0; rw = 0; ce = 0; rr = 0; ww = 0; as = 0; bt = 0;
      dst = 0; nph = 0;
    end
    e.v = {fe, ex, me, ie, rw, 3'(dst), ce, rr, ww, as, bt};
    e.id = ncyc;
    q.push_back(e);
    ncyc++;
    ph = nph;
  endtask

  // monitor: compare the DUT against the oldest prediction
  always @(negedge CLK) begin
    exp_t e;
    logic [12:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {fetch, execute, memory, ir_en, reg_write, reg_dest,
             cc_en, mem_ren, mem_wen, addr_sel, branch_taken};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL outs cyc%0d got %b want %b (ph ex me ie rw dst ce rr ww as bt)",
                 e.id, got, e.v);
      end
    end
  end

  initial begin
    bit r;
    logic [15:0] ri;
    RST = 1'b1; ir = '0; cc = '0; mem_rdy = 1'b1;
    @(posedge CLK);
    cyc(1, 16'h0000, 4'h0, 1);
    cyc(1, 16'h0000, 4'h0, 1);
    cyc(0, 16'h0A2C, 4'h0, 1);
    cyc(0, 16'h0A2C, 4'h0, 0);
    // fetch stall then ALU with S bit
    cyc(0, 16'h0A2C, 4'h0, 0);
    cyc(0, 16'h0A2C, 4'h0, 0);
    cyc(0, 16'h0A2C, 4'h0, 0);
    cyc(0, 16'h0A2C, 4'h0, 1);
    cyc(0, 16'h0A2C, 4'h0, 1);
    // load with memory wait
    cyc(0, 16'hD385, 4'h0, 1);
    cyc(0, 16'hD385, 4'h0, 0);
    cyc(0, 16'hD385, 4'h0, 0);
    cyc(0, 16'hD385, 4'h0, 0);
    cyc(0, 16'hD385, 4'h0, 1);
    // store
    cyc(0, 16'hDB85, 4'hF, 1);
    cyc(0, 16'hDB85, 4'hF, 1);
    cyc(0, 16'hDB85, 4'hF, 1);
    // BEQ taken / not taken
    cyc(0, 16'hF705, 4'b0100, 1);
    cyc(0, 16'hF705, 4'b0100, 1);
    cyc(0, 16'hF705, 4'b0000, 1);
    cyc(0, 16'hF705, 4'b0000, 1);
    // full cond x flags sweep
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        ri = {4'hE, 4'(c), 8'h00};
        cyc(0, ri, 4'(f), 1);
        cyc(0, ri, 4'(f), 1);
      end
    end
    // reset during a stalled store
    cyc(0, 16'hDB85, 4'h0, 1);
    cyc(0, 16'hDB85, 4'h0, 1);
    cyc(0, 16'hDB85, 4'h0, 0);
    cyc(1, 16'hDB85, 4'h0, 0);
    cyc(0, 16'hDB85, 4'h0, 0);
    cyc(0, 16'hDB85, 4'h0, 1);
    // random traffic, ir changes only while fetching
    ri = 16'h0000;
    for (int k = 0; k < 3000; k++) begin
      if (ph == 0) ri = 16'($urandom);
      r = ($urandom_range(0, 49) == 0);
      cyc(r, ri, 4'($urandom), bit'($urandom_range(0, 1)));
    end
    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
